adc_avg_decim: RTL and testbench

//  Boxcar averager between ADC_MUX and ADC_fp. On each SPGD measurement request it skips a settle window,

---
 rtl/adc_avg_pkg.sv | 31 +++
 rtl/adc_avg_decim_if.sv | 27 ++
 rtl/adc_avg_round.sv | 55 +++++
 rtl/adc_avg_decim.sv | 104 ++++++++++
 tb/tb_adc_avg_decim.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_avg_pkg.sv
// Shared types and helpers for the adc_avg_decim boxcar averager.
// Holds the FSM state encoding, the default accumulator width and the
// sample-count clamp used when a measurement request is latched.
package adc_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int ADC_WIDTH_DEF    = 12;
  localparam int AVG_LOG2_MAX_DEF = 8;

  // Accumulator width: sample width plus headroom for 2^AVG_LOG2_MAX samples.
  function automatic int acc_width(input int adc_w, input int log2_max);
    return adc_w + log2_max;
  endfunction

  localparam int ACC_W = acc_width(ADC_WIDTH_DEF, AVG_LOG2_MAX_DEF);

  // Requested log2(sample count) limited to the largest supported value.
  function automatic logic [3:0] clamp_k(input logic [3:0] k, input int k_max);
    if (int'(k) > k_max) begin
      return 4'(k_max);
    end
    return k;
  endfunction

endpackage

// File: rtl/adc_avg_decim_if.sv
// Control/data bundle between the measurement sequencer (master) and the
// adc_avg_decim averager (slave). Clock and reset are kept outside.
interface adc_avg_decim_if #(
  parameter int ADC_WIDTH    = 12,
  parameter int SETTLE_WIDTH = 16
);

  logic                           CLR;
  logic                           START;
  logic [3:0]                     AVG_LOG2;
  logic [SETTLE_WIDTH-1:0]        SETTLE_CYC;
  logic signed [ADC_WIDTH-1:0]    ADC_IN;
  logic signed [ADC_WIDTH-1:0]    AVG_OUT;
  logic                           AVG_VALID;
  logic                           BUSY;

  modport master (
    output CLR, START, AVG_LOG2, SETTLE_CYC, ADC_IN,
    input  AVG_OUT, AVG_VALID, BUSY
  );

  modport slave (
    input  CLR, START, AVG_LOG2, SETTLE_CYC, ADC_IN,
    output AVG_OUT, AVG_VALID, BUSY
  );

endinterface

// File: rtl/adc_avg_round.sv
// Combinational scaling of the final accumulator sum down to one sample.
// Optional build macro: ADC_AVG_ROUND_EN selects round-half-up with positive
// saturation; without it the sum is truncated (arithmetic shift, toward -inf).
module adc_avg_round
  import adc_avg_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int ACC_SW    = ACC_W
) (
  input  logic signed [ACC_SW-1:0]    acc,
  input  logic [3:0]                  k,
  output logic signed [ADC_WIDTH-1:0] avg
);

`ifdef ADC_AVG_ROUND_EN

  localparam logic signed [ACC_SW:0]      MAX_EXT = (ACC_SW+1)'((1 << (ADC_WIDTH-1)) - 1);
  localparam logic signed [ADC_WIDTH-1:0] MAX_OUT = {1'b0, {(ADC_WIDTH-1){1'b1}}};

  // Add half an LSB of the result (none for k=0), shift, clip the top end.
  function automatic logic signed [ADC_WIDTH-1:0] shift_round_sat(
    input logic signed [ACC_SW-1:0] a,
    input logic [3:0]               sh
  );
    logic [ACC_SW:0]        bias;
    logic signed [ACC_SW:0] biased;
    logic signed [ACC_SW:0] shifted;
    bias    = ((ACC_SW+1)'(1) << sh) >> 1;
    biased  = {a[ACC_SW-1], a} + $signed(bias);
    shifted = biased >>> sh;
    if (shifted > MAX_EXT) begin
      return MAX_OUT;
    end
    return $signed(shifted[ADC_WIDTH-1:0]);
  endfunction

  assign avg = shift_round_sat(acc, k);

`else

  // Plain arithmetic shift; the sum of 2^k samples always fits after scaling.
  function automatic logic signed [ADC_WIDTH-1:0] shift_trunc(
    input logic signed [ACC_SW-1:0] a,
    input logic [3:0]               sh
  );
    logic signed [ACC_SW-1:0] shifted;
    shifted = a >>> sh;
    return $signed(shifted[ADC_WIDTH-1:0]);
  endfunction

  assign avg = shift_trunc(acc, k);

`endif

endmodule

// File: rtl/adc_avg_decim.sv
// Boxcar averager between the ADC mux and the float converter. A START pulse
// skips SETTLE_CYC cycles, sums 2^k samples and emits one averaged sample with
// a single-cycle AVG_VALID. Rounding mode is chosen by ADC_AVG_ROUND_EN
// inside adc_avg_round only.
module adc_avg_decim
  import adc_avg_pkg::*;
#(
  parameter int ADC_WIDTH    = 12,
  parameter int AVG_LOG2_MAX = 8,
  parameter int SETTLE_WIDTH = 16
) (
  input logic              ADC_CLK,
  input logic              RST_N,
  adc_avg_decim_if.slave   bus
);

  localparam int ACC_SW = acc_width(ADC_WIDTH, AVG_LOG2_MAX);
  localparam int CNT_W  = AVG_LOG2_MAX + 1;

  state_t                      state;
  logic [3:0]                  k_reg;
  logic [SETTLE_WIDTH-1:0]     settle_cnt;
  logic [CNT_W-1:0]            sample_cnt;
  logic [CNT_W-1:0]            sample_inc;
  logic [CNT_W-1:0]            n_samp;
  logic                        last_sample;
  logic signed [ACC_SW-1:0]    acc;
  logic signed [ACC_SW-1:0]    acc_sum;
  logic signed [ADC_WIDTH-1:0] avg_out;
  logic signed [ADC_WIDTH-1:0] avg_scaled;

  // The running sum including this cycle's sample feeds both the accumulator
  // and the scaler, so the result is ready on the edge that ends ACCUM.
  assign acc_sum     = acc + $signed({{AVG_LOG2_MAX{bus.ADC_IN[ADC_WIDTH-1]}}, bus.ADC_IN});
  assign sample_inc  = sample_cnt + CNT_W'(1);
  assign n_samp      = CNT_W'(1) << k_reg;
  assign last_sample = (sample_inc == n_samp);

  adc_avg_round #(
    .ADC_WIDTH (ADC_WIDTH),
    .ACC_SW    (ACC_SW)
  ) u_round (
    .acc (acc_sum),
    .k   (k_reg),
    .avg (avg_scaled)
  );

  // Measurement sequencer: settle, accumulate, publish; CLR aborts any run.
  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      k_reg      <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      avg_out    <= '0;
    end else if (bus.CLR) begin
      state      <= ST_IDLE;
      k_reg      <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      avg_out    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            k_reg      <= clamp_k(bus.AVG_LOG2, AVG_LOG2_MAX);
            settle_cnt <= bus.SETTLE_CYC;
            sample_cnt <= '0;
            acc        <= '0;
            state      <= (bus.SETTLE_CYC != '0) ? ST_SETTLE : ST_ACCUM;
          end else begin
            state      <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt <= SETTLE_WIDTH'(1)) begin
            settle_cnt <= '0;
            state      <= ST_ACCUM;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
          end
        end
        ST_ACCUM: begin
          acc        <= acc_sum;
          sample_cnt <= sample_inc;
          if (last_sample) begin
            avg_out <= avg_scaled;
            state   <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.AVG_OUT   = avg_out;
  assign bus.AVG_VALID = (state == ST_DONE);
  assign bus.BUSY      = (state == ST_SETTLE) || (state == ST_ACCUM);

endmodule

// File: tb/tb_adc_avg_decim.sv
// Directed bench for adc_avg_decim: a table of averaging runs plus hand-built
// sequences for reset, back-to-back START, START-while-busy and CLR.
module tb_adc_avg_decim;

  localparam int ADC_WIDTH    = 12;
  localparam int AVG_LOG2_MAX = 8;
  localparam int SETTLE_WIDTH = 16;
`ifdef ADC_AVG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  adc_avg_decim_if #(.ADC_WIDTH(ADC_WIDTH), .SETTLE_WIDTH(SETTLE_WIDTH)) ifc ();

  adc_avg_decim #(
    .ADC_WIDTH    (ADC_WIDTH),
    .AVG_LOG2_MAX (AVG_LOG2_MAX),
    .SETTLE_WIDTH (SETTLE_WIDTH)
  ) dut (
    .ADC_CLK (clk),
    .RST_N   (rst_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] k;
    int         s;
    int         v0, v1, v2, v3;
    int         exp_trn;
    int         exp_rnd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int samp(input vec_t v, input int i);
    case (i)
      0:       return v.v0;
      1:       return v.v1;
      2:       return v.v2;
      default: return v.v3;
    endcase
  endfunction

  // Issue START in the current cycle, then watch BUSY/AVG_VALID cycle by cycle.
  task automatic run_vec(input vec_t v);
    int keff, n, vcyc, nvalid, got, idx;
    bit busy_bad;
    keff     = (int'(v.k) > AVG_LOG2_MAX) ? AVG_LOG2_MAX : int'(v.k);
    n        = 1 << keff;
    vcyc     = -1;
    nvalid   = 0;
    got      = 0;
    busy_bad = 1'b0;
    ifc.START      = 1'b1;
    ifc.AVG_LOG2   = v.k;
    ifc.SETTLE_CYC = SETTLE_WIDTH'(v.s);
    ifc.ADC_IN     = 12'h5A5;
    for (int c = 1; c <= v.s + n + 4; c++) begin
      tick();
      ifc.START      = 1'b0;
      ifc.AVG_LOG2   = 4'd3;
      ifc.SETTLE_CYC = '1;
      if (ifc.BUSY !== ((c <= v.s + n) ? 1'b1 : 1'b0)) busy_bad = 1'b1;
      if (ifc.AVG_VALID === 1'b1) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = c;
          got  = int'(ifc.AVG_OUT);
        end
      end
      idx = c - v.s - 1;
      if (idx >= 0 && idx < n) ifc.ADC_IN = ADC_WIDTH'(samp(v, idx));
      else                     ifc.ADC_IN = 12'h5A5;
    end
    check({v.name, " valid_cycle"}, vcyc, v.s + n + 1);
    check({v.name, " valid_count"}, nvalid, 1);
    check({v.name, " busy_window"}, int'(busy_bad), 0);
    check({v.name, " avg_out"}, got, ROUND ? v.exp_rnd : v.exp_trn);
  endtask

  initial begin
    int v1c, v2c, nv, got;

    vecs[0] = '{"k2_s3_const100", 4'd2,  3,   100,   100,   100,   100,   100,   100};
    vecs[1] = '{"k2_neg_sum7",    4'd2,  0,    -1,    -2,    -2,    -2,    -2,    -2};
    vecs[2] = '{"k2_pos_sum3",    4'd2,  0,     1,     1,     1,     0,     0,     1};
    vecs[3] = '{"k8_max",         4'd8,  0,  2047,  2047,  2047,  2047,  2047,  2047};
    vecs[4] = '{"k8_min",         4'd8,  0, -2048, -2048, -2048, -2048, -2048, -2048};
    vecs[5] = '{"k15_clamp",      4'd15, 0,  2047,  2047,  2047,  2047,  2047,  2047};
    vecs[6] = '{"k0_min_latency", 4'd0,  0,    -5,    -5,    -5,    -5,    -5,    -5};
    vecs[7] = '{"k1_s2_sum7",     4'd1,  2,     3,     4,     4,     4,     3,     4};
    vecs[8] = '{"k1_neg_sum7",    4'd1,  0,    -3,    -4,    -4,    -4,    -4,    -3};
    vecs[9] = '{"k2_near_max",    4'd2,  0,  2047,  2047,  2047,  2046,  2046,  2047};

    ifc.CLR        = 1'b0;
    ifc.START      = 1'b0;
    ifc.AVG_LOG2   = 4'd0;
    ifc.SETTLE_CYC = '0;
    ifc.ADC_IN     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset avg_out",   int'(ifc.AVG_OUT), 0);
    check("reset busy",      int'(ifc.BUSY), 0);
    check("reset avg_valid", int'(ifc.AVG_VALID), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // START during ACCUM ignored; START in the DONE cycle begins a second run.
    v1c = -1; v2c = -1; nv = 0; got = 0;
    ifc.START = 1'b1; ifc.AVG_LOG2 = 4'd1; ifc.SETTLE_CYC = 16'd1; ifc.ADC_IN = 12'sd10;
    for (int c = 1; c <= 14; c++) begin
      tick();
      ifc.START = 1'b0;
      if (ifc.AVG_VALID === 1'b1) begin
        nv++;
        got = int'(ifc.AVG_OUT);
        if (v1c < 0) v1c = c; else if (v2c < 0) v2c = c;
      end
      if (c == 2 || c == 4) ifc.START = 1'b1;
    end
    check("b2b first_valid",  v1c, 4);
    check("b2b second_valid", v2c, 8);
    check("b2b valid_count",  nv, 2);
    check("b2b avg_out",      got, 10);

    // CLR with simultaneous START during SETTLE aborts the run.
    ifc.START = 1'b1; ifc.AVG_LOG2 = 4'd1; ifc.SETTLE_CYC = 16'd5; ifc.ADC_IN = 12'sd20;
    tick();
    ifc.START = 1'b0;
    check("clr pre busy", int'(ifc.BUSY), 1);
    tick();
    ifc.CLR = 1'b1; ifc.START = 1'b1;
    tick();
    ifc.CLR = 1'b0; ifc.START = 1'b0;
    check("clr busy",    int'(ifc.BUSY), 0);
    check("clr avg_out", int'(ifc.AVG_OUT), 0);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ifc.AVG_VALID === 1'b1) nv++;
    end
    check("clr no_valid", nv, 0);
    run_vec('{"after_clr", 4'd1, 0, 20, 20, 20, 20, 20, 20});
    tick();

    // Asynchronous reset in the middle of ACCUM.
    ifc.START = 1'b1; ifc.AVG_LOG2 = 4'd4; ifc.SETTLE_CYC = '0; ifc.ADC_IN = 12'sd7;
    tick();
    ifc.START = 1'b0;
    repeat (4) tick();
    check("rst pre busy", int'(ifc.BUSY), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async avg_out",   int'(ifc.AVG_OUT), 0);
    check("rst async busy",      int'(ifc.BUSY), 0);
    check("rst async avg_valid", int'(ifc.AVG_VALID), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ifc.AVG_VALID === 1'b1) nv++;
    end
    check("rst no_valid_after", nv, 0);
    check("rst idle busy", int'(ifc.BUSY), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
